// File: rtl/counter_arb_if.sv
// counter_arb_if: request/grant bundle for the shared step-counter arbiter.
// master drives req; slave (the arbiter) drives grant, busy, cnt, wrap, done.
interface counter_arb_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         busy;
    logic [W-1:0] cnt;
    logic         wrap;
    logic [N-1:0] done;

    modport master (
        output req,
        input  grant, busy, cnt, wrap, done
    );

    modport slave (
        input  req,
        output grant, busy, cnt, wrap, done
    );
endinterface

// File: rtl/counter_arb.sv
// counter_arb: round-robin owner of a wrapping 1..KMAX step counter.
// Define COUNTER_ARB_ASSERT_EN to compile the built-in safety properties.
module counter_arb #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int BURST = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    counter_arb_if.slave   io_bus
);
    localparam logic [W-1:0] KMAX = {W{1'b1}};
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_grant, w_grant_nxt;
    logic [N-1:0] r_done, w_done_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic [PW-1:0] r_own, w_own_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic [W-1:0] r_cnt, w_cnt_nxt;
    logic         r_wrap, w_wrap_nxt;

    logic          w_hit;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_own_inc;
    logic [W-1:0]  w_cnt_step;
    logic          w_live;

    // First live request at or after the pointer, wrapping modulo N.
    always_comb begin
        int j;
        logic [PW-1:0] k;
        w_hit = 1'b0;
        w_sel = '0;
        j     = 0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N) j = j - N;
            k = PW'(j);
            if (!w_hit && io_bus.req[k]) begin
                w_hit = 1'b1;
                w_sel = k;
            end
        end
    end

    assign w_own_inc  = (r_own == PW'(N - 1)) ? '0 : r_own + 1'b1;
    assign w_live     = io_bus.req[r_own];
    assign w_cnt_step = (r_cnt == KMAX) ? W'(1) : r_cnt + W'(1);

    // Next-state: grant in IDLE, step/finish/abort in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_wrap_nxt  = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_own_nxt   = r_own;
        w_bcnt_nxt  = r_bcnt;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_grant_nxt = N'(1) << w_sel;
                    w_own_nxt   = w_sel;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_live) begin
                    w_cnt_nxt  = w_cnt_step;
                    w_wrap_nxt = (r_cnt == KMAX);
                    w_bcnt_nxt = r_bcnt + 1'b1;
                    if (r_bcnt == BW'(BURST - 1)) begin
                        w_done_nxt  = r_grant;
                        w_grant_nxt = '0;
                        w_ptr_nxt   = w_own_inc;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_own_inc;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State registers; reset forces the counter back to 1 immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_ptr   <= '0;
            r_own   <= '0;
            r_bcnt  <= '0;
            r_cnt   <= W'(1);
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign io_bus.grant = r_grant;
    assign io_bus.busy  = |r_grant;
    assign io_bus.cnt   = r_cnt;
    assign io_bus.wrap  = r_wrap;
    assign io_bus.done  = r_done;

`ifdef COUNTER_ARB_ASSERT_EN
    a_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(r_grant));
    a_cnt_nz: assert property (@(posedge i_clk) disable iff (i_rst)
        r_cnt != '0);
    a_cnt_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_cnt != $past(r_cnt)) |-> $past(|r_grant));
    a_done: assert property (@(posedge i_clk) disable iff (i_rst)
        (|r_done) |-> ($past(r_grant) == r_done));
    a_wrap: assert property (@(posedge i_clk) disable iff (i_rst)
        r_wrap |-> (r_cnt == W'(1)));
`else
    // Properties are left out of this build; behaviour is unchanged.
`endif
endmodule

// File: tb/tb_counter_arb.sv
// tb_counter_arb: directed stimulus with a queued expected-output scoreboard.
// Stimulus pushes the outputs expected after each edge; a monitor pops them.
module tb_counter_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_arb_if #(.W(4), .N(4)) bus ();

    counter_arb #(.W(4), .N(4), .BURST(3)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] c;
        logic [3:0] d;
        logic       w;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic rv, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] c,
                       input logic [3:0] d, input logic w);
        @(negedge clk);
        #1;
        rst     = rv;
        bus.req = r;
        q.push_back(exp_t'{g, c, d, w});
    endtask

    // Five back-to-back bursts with req held; rr selects req=1111 vs 0001.
    task automatic bursts(input logic rr);
        logic [3:0] gt [5];
        logic [3:0] ct [20];
        logic [3:0] r;
        logic [3:0] g;
        gt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ct = '{4'd1, 4'd2, 4'd3, 4'd4,
               4'd4, 4'd5, 4'd6, 4'd7,
               4'd7, 4'd8, 4'd9, 4'd10,
               4'd10, 4'd11, 4'd12, 4'd13,
               4'd13, 4'd14, 4'd15, 4'd1};
        r = rr ? 4'b1111 : 4'b0001;
        for (int b = 0; b < 5; b++) begin
            g = rr ? gt[b] : 4'b0001;
            for (int s = 0; s < 4; s++)
                cyc(1'b0, r, (s < 3) ? g : 4'b0000, ct[b*4+s],
                    (s == 3) ? g : 4'b0000, (b == 4) && (s == 3));
        end
    endtask

    // Monitor: compare DUT outputs to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", bus.grant, e.g);
                chk("cnt",   bus.cnt,   e.c);
                chk("done",  bus.done,  e.d);
                chk("wrap",  bus.wrap,  e.w);
                chk("busy",  bus.busy,  |e.g);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;
        #1;
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_cnt",   bus.cnt,   4'd1);
        chk("rst_busy",  bus.busy,  1'b0);

        cyc(1'b1, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);
        repeat (5) cyc(1'b0, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);

        cyc(1'b0, 4'b0001, 4'b0001, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd3, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0000, 4'd4, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd4, 4'b0000, 1'b0);

        cyc(1'b1, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);
        bursts(1'b1);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);

        cyc(1'b1, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);
        bursts(1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);

        cyc(1'b0, 4'b0010, 4'b0010, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0010, 4'b0010, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0001, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0001, 4'd3, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0001, 4'd4, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0000, 4'd5, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0010, 4'd5, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd5, 4'b0000, 1'b0);

        cyc(1'b1, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd3, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_grant", bus.grant, 4'b0000);
        chk("midrst_cnt",   bus.cnt,   4'd1);
        chk("midrst_done",  bus.done,  4'b0000);
        chk("midrst_busy",  bus.busy,  1'b0);
        @(posedge clk);
        #1;
        chk("midrst_edge_done", bus.done, 4'b0000);
        chk("midrst_edge_cnt",  bus.cnt,  4'd1);
        cyc(1'b1, 4'b0001, 4'b0000, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 4'b0001, 4'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 4'd1, 4'b0000, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_arb.md
# counter_arb

Round-robin scheduler that shares one wrapping step counter between N requesters. Each grant lets the owner advance the counter by a fixed burst of steps. The block sits in front of the counter datapath and owns its enable, so the counter never advances without exactly one registered owner. It also carries its own safety properties for the model checker.

## Interface
- `W`, default 4: counter width; `KMAX = 2^W-1`.
- `N`, default 4: number of requesters.
- `BURST`, default 3: counter steps per grant; legal range 1..2^W-1.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, N: request level per requester; must be held for the whole burst.
- `grant`, output, N: registered; one-hot or zero.
- `busy`, output, 1: equals `|grant`.
- `cnt`, output, W: shared counter value; range 1..KMAX, never 0.
- `wrap`, output, 1: one-cycle pulse after `cnt` steps from KMAX to 1.
- `done`, output, N: one-cycle pulse marking a completed burst for that requester.

## Operation
- On reset, these values apply immediately (asynchronously):
  - `cnt=1`, `grant=0`, `done=0`, `wrap=0`, `busy=0`.
  - Round-robin pointer `ptr=0`; state IDLE.
- Only `clk` and `rst` drive state.

States:
- IDLE:
  - If `req != 0`, select the first set bit searching `ptr, ptr+1, …, N-1, 0, …` (mod N).
  - Register that requester into `grant`, clear the burst count `bcnt` to 0, and go to RUN.
  - If `req == 0`, stay in IDLE.
- RUN, owner g, at each edge:
  - If `req[g]=1`, `cnt` steps and `bcnt` increments.
  - When this step is the BURST-th, in the same edge: `done[g]` goes to 1, `grant` goes to 0, `ptr` becomes `g+1 mod N`, and the state returns to IDLE.
  - If `req[g]=0` (abort): `cnt` holds, `grant` goes to 0, `done` stays 0, `ptr` becomes `g+1 mod N`, and the state returns to IDLE.

Counter step rule:
- `cnt` becomes 1 if `cnt==KMAX`, otherwise `cnt+1` (W-bit arithmetic).
- `wrap` is registered and set on the edge that performs the KMAX to 1 step.
- `cnt` changes only in RUN, and only for an owner whose request is live.

Other rules:
- Requests from non-owners during RUN are ignored. They are served later in pointer order, with no starvation.
- `bcnt` is `$clog2(BURST+1)` bits wide and is internal.

## Timing
- Request-to-grant latency is 1 cycle: `req` seen in IDLE at edge k gives `grant` high after edge k.
- The first step happens at edge k+1; the last step at edge k+BURST.
- `done` and `wrap` are high only for the cycle after the edge that sets them.
- After every grant release there is at least 1 idle cycle (`grant=0`). The next grant is issued at the following edge, so back-to-back bursts have a period of BURST+1 cycles.
- Reset asserted mid-burst clears everything immediately. It produces no `done`, and `cnt` returns to 1.
- A request that drops and rises again within the same cycle is indistinguishable from a held request.

## Configuration
- `COUNTER_ARB_ASSERT_EN` defined: compile in these assertion properties:
  - `grant` is one-hot or zero.
  - `cnt != 0`.
  - `cnt` changes only while `busy`.
  - `done` implies `grant` at the previous cycle was equal to `done`.
  - `wrap` implies `cnt==1`.
- Undefined: no properties are compiled; functional behaviour is identical.

## Test plan
- Reset then idle: assert `rst`, release it, hold `req=0` for 5 cycles. Expect `cnt=1`, `grant=0`, `busy=0`, `done=0` throughout.
- Single burst (W=4, BURST=3): `req=0001` held from cycle 0.
  - `grant=0001` after edge 0.
  - `cnt` goes 2, 3, 4 over the next 3 edges.
  - `done=0001` pulses with `cnt=4`, and `grant=0` in that cycle.
- Round robin: `req=1111` held. Grants occur in order 0001, 0010, 0100, 1000, 0001, each lasting 3 cycles with 1 idle cycle between.
- Wrap: `req=0001` held for 5 bursts.
  - `cnt` after each burst is 4, 7, 10, 13.
  - The fifth burst steps 14, 15, 1; `wrap=1` for one cycle when `cnt=1`.
  - `cnt` is never 0.
- Abort: `req=0010` starting with `cnt=1`; drop `req[1]` after 1 step.
  - `cnt` holds at 2, `grant` goes to 0, and `done` stays 0.
  - `ptr` advances, so a later `req=0011` grants 0001 first.
- Reset mid-burst: assert `rst` asynchronously between edges while `grant=0001` and `cnt=3`. Outputs go to `grant=0` and `cnt=1` before the next edge, and no `done` is produced.
